// File: rtl/mac_os_ctrl.sv
// mac_os_ctrl: per-tile sequencer for the 8x8 output-stationary MAC array
module mac_os_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int row_aw  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 k_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 inst_w,
  output logic [3:0]                 accum_limit,
  output logic                       act_rd,
  input  logic                       act_empty,
  output logic                       wgt_rd,
  input  logic                       wgt_empty,
  input  logic [row*col-1:0]         os_ready,
  input  logic [psum_bw*row*col-1:0] os_output,
  output logic                       ofifo_wr,
  input  logic                       ofifo_full,
  output logic [psum_bw*col-1:0]     ofifo_data,
  output logic [row_aw-1:0]          ofifo_row
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, WAIT_RDY, WRITE, DONE} state_t;
  localparam logic [3:0] DRAIN_LAST = 4'(row + col - 2);
  localparam logic [row_aw-1:0] ROW_LAST = row_aw'(row - 1);
  state_t state;
  logic [3:0] issue_cnt, drain_cnt;
  logic [row_aw-1:0] row_cnt;
  logic go;
  logic [psum_bw*col-1:0] rows [row];
  if (bw < 1 || row_aw != $clog2(row)) begin : g_bad_params
    $error("mac_os_ctrl: inconsistent parameters");
  end
  for (genvar r = 0; r < row; r++) begin : g_rows
    assign rows[r] = os_output[psum_bw*col*r +: psum_bw*col];
  end
  assign go          = state == LOAD && !act_empty && !wgt_empty;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign inst_w      = state == CLEAR ? 2'b10 : {1'b0, go};
  assign act_rd      = go;
  assign wgt_rd      = go;
  assign ofifo_wr    = state == WRITE && !ofifo_full;
  assign ofifo_row   = row_cnt;
  assign ofifo_data  = rows[row_cnt];
  // tile sequencing: clear, issue K paired pops, drain skew, wait ready, write rows
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      accum_limit <= '0;
      err         <= 1'b0;
      issue_cnt   <= '0;
      drain_cnt   <= '0;
      row_cnt     <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            if (k_len == '0) err <= 1'b1;
            else begin
              err         <= 1'b0;
              accum_limit <= k_len;
              state       <= CLEAR;
            end
          end
        CLEAR: begin
          issue_cnt <= '0;
          state     <= LOAD;
        end
        LOAD:
          if (go) begin
            issue_cnt <= issue_cnt + 4'd1;
            if (issue_cnt + 4'd1 == accum_limit) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        DRAIN: begin
          drain_cnt <= drain_cnt + 4'd1;
          if (drain_cnt == DRAIN_LAST) state <= WAIT_RDY;
        end
        WAIT_RDY:
          if (&os_ready) begin
            row_cnt <= '0;
            state   <= WRITE;
          end
        WRITE:
          if (!ofifo_full) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == ROW_LAST) state <= DONE;
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mac_os_ctrl.sv
// tb_mac_os_ctrl: directed scenario bench for mac_os_ctrl
module tb_mac_os_ctrl;
  localparam int PB = 16, C = 8, R = 8, RW = 3;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] k_len = '0;
  logic busy, done, err, act_rd, wgt_rd, ofifo_wr;
  logic [1:0] inst_w;
  logic [3:0] accum_limit;
  logic act_empty = 0, wgt_empty = 0, ofifo_full = 0;
  logic [R*C-1:0] os_ready = '1;
  logic [PB*R*C-1:0] os_output;
  logic [PB*C-1:0] ofifo_data;
  logic [RW-1:0] ofifo_row;
  int pass = 0, total = 0;
  int clear_cyc, n_clear, n_exec, last_exec, pair_bad, stall_bad, nop_bad;
  int n_push, first_push, push_bad, done_cyc, n_done, bp_bad, alim1;

  always #5 clk = ~clk;

  mac_os_ctrl #(.bw(4), .psum_bw(PB), .col(C), .row(R), .row_aw(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .err(err), .inst_w(inst_w), .accum_limit(accum_limit), .act_rd(act_rd),
    .act_empty(act_empty), .wgt_rd(wgt_rd), .wgt_empty(wgt_empty), .os_ready(os_ready),
    .os_output(os_output), .ofifo_wr(ofifo_wr), .ofifo_full(ofifo_full),
    .ofifo_data(ofifo_data), .ofifo_row(ofifo_row));

  function automatic logic [PB*C-1:0] exp_row(input int r);
    exp_row = '0;
    for (int c = 0; c < C; c++) exp_row[PB*c +: PB] = PB'(16'hA000 + r*16 + c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one tile and records what the DUT does each cycle; cycle 1 follows the start edge.
  task automatic run(input logic [3:0] k, input int act_st, input int wgt_st, input int full_from,
                     input int full_len, input int rdy_end, input int start2);
    clear_cyc = -1; n_clear = 0; n_exec = 0; last_exec = -1; pair_bad = 0; stall_bad = 0;
    nop_bad = 0; n_push = 0; first_push = -1; push_bad = 0; done_cyc = -1; n_done = 0;
    bp_bad = 0; alim1 = -1;
    k_len = k; start = 1;
    tick();
    start = 0;
    for (int c = 1; c < 100; c++) begin
      if (c > 1) tick();
      start = (c == start2);
      if (c == start2) k_len = 4'd3;
      act_empty = (c == act_st);
      wgt_empty = (c == wgt_st);
      ofifo_full = (c >= full_from && c < full_from + full_len);
      os_ready = (c <= rdy_end) ? ~(64'd1 << 5) : '1;
      #1;
      if (c == 1) alim1 = int'(accum_limit);
      if (inst_w == 2'b10) begin n_clear++; if (clear_cyc < 0) clear_cyc = c; end
      if (act_rd !== wgt_rd || act_rd !== (inst_w == 2'b01)) pair_bad++;
      if (inst_w == 2'b01) begin n_exec++; last_exec = c; end
      if ((c == act_st || c == wgt_st) && (act_rd || wgt_rd || inst_w != 2'b00)) stall_bad++;
      if (n_exec == int'(k) && c > last_exec && inst_w != 2'b00) nop_bad++;
      if (ofifo_full && (ofifo_wr !== 1'b0 || ofifo_row !== RW'(2) || ofifo_data !== exp_row(2))) bp_bad++;
      if (ofifo_wr) begin
        if (first_push < 0) first_push = c;
        if (ofifo_row !== RW'(n_push) || ofifo_data !== exp_row(n_push)) push_bad++;
        n_push++;
      end
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (done_cyc >= 0 && c == done_cyc + 3) break;
    end
    start = 0; act_empty = 0; wgt_empty = 0; ofifo_full = 0; os_ready = '1;
  endtask

  task automatic test_reset();
    #2 reset = 0;
    tick(); tick();
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass++;
    total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else pass++;
    total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else pass++;
    total++; if (inst_w !== 2'b00) $display("FAIL rst_inst got %b want 00", inst_w); else pass++;
    total++; if (accum_limit !== 4'd0) $display("FAIL rst_alim got %0d want 0", accum_limit); else pass++;
    total++; if ({act_rd, wgt_rd, ofifo_wr} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {act_rd, wgt_rd, ofifo_wr}); else pass++;
    total++; if (ofifo_row !== '0) $display("FAIL rst_row got %0d want 0", ofifo_row); else pass++;
    total++; if (ofifo_data !== exp_row(0)) $display("FAIL rst_data got %h want %h", ofifo_data, exp_row(0)); else pass++;
    reset = 1;
    tick();
  endtask

  task automatic test_basic();
    run(4'd4, -1, -1, 0, 0, 0, -1);
    total++; if (clear_cyc !== 1 || n_clear !== 1) $display("FAIL basic_clear got cyc %0d n %0d want 1 1", clear_cyc, n_clear); else pass++;
    total++; if (alim1 !== 4) $display("FAIL basic_alim got %0d want 4", alim1); else pass++;
    total++; if (n_exec !== 4 || last_exec !== 5) $display("FAIL basic_exec got n %0d last %0d want 4 5", n_exec, last_exec); else pass++;
    total++; if (pair_bad !== 0) $display("FAIL basic_pairing got %0d want 0", pair_bad); else pass++;
    total++; if (nop_bad !== 0) $display("FAIL basic_nop got %0d want 0", nop_bad); else pass++;
    total++; if (first_push !== 22 || n_push !== 8) $display("FAIL basic_push got first %0d n %0d want 22 8", first_push, n_push); else pass++;
    total++; if (push_bad !== 0) $display("FAIL basic_rows got %0d want 0", push_bad); else pass++;
    total++; if (done_cyc !== 30 || n_done !== 1) $display("FAIL basic_done got cyc %0d n %0d want 30 1", done_cyc, n_done); else pass++;
    total++; if (busy !== 1'b0 || accum_limit !== 4'd4) $display("FAIL basic_end got busy %b alim %0d want 0 4", busy, accum_limit); else pass++;
  endtask

  task automatic test_stall();
    run(4'd3, 3, 5, 0, 0, 0, -1);
    total++; if (stall_bad !== 0) $display("FAIL stall_nop got %0d want 0", stall_bad); else pass++;
    total++; if (pair_bad !== 0) $display("FAIL stall_pairing got %0d want 0", pair_bad); else pass++;
    total++; if (n_exec !== 3 || last_exec !== 6) $display("FAIL stall_exec got n %0d last %0d want 3 6", n_exec, last_exec); else pass++;
    total++; if (done_cyc !== 31) $display("FAIL stall_done got %0d want 31", done_cyc); else pass++;
  endtask

  task automatic test_backpressure();
    run(4'd4, -1, -1, 24, 3, 0, -1);
    total++; if (bp_bad !== 0) $display("FAIL bp_hold got %0d want 0", bp_bad); else pass++;
    total++; if (n_push !== 8 || push_bad !== 0) $display("FAIL bp_rows got n %0d bad %0d want 8 0", n_push, push_bad); else pass++;
    total++; if (done_cyc !== 33) $display("FAIL bp_done got %0d want 33", done_cyc); else pass++;
  endtask

  task automatic test_late_ready();
    run(4'd4, -1, -1, 0, 0, 30, -1);
    total++; if (first_push !== 32) $display("FAIL late_first_push got %0d want 32", first_push); else pass++;
    total++; if (n_push !== 8 || push_bad !== 0) $display("FAIL late_rows got n %0d bad %0d want 8 0", n_push, push_bad); else pass++;
    total++; if (done_cyc !== 40) $display("FAIL late_done got %0d want 40", done_cyc); else pass++;
  endtask

  task automatic test_error_ignore();
    k_len = 4'd0; start = 1;
    tick();
    start = 0;
    #1;
    total++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_set got err %b busy %b want 1 0", err, busy); else pass++;
    tick();
    total++; if (err !== 1'b1 || inst_w !== 2'b00) $display("FAIL err_sticky got err %b inst %b want 1 00", err, inst_w); else pass++;
    run(4'd15, -1, -1, 0, 0, 0, 5);
    total++; if (err !== 1'b0) $display("FAIL err_clear got %b want 0", err); else pass++;
    total++; if (n_exec !== 15) $display("FAIL ign_exec got %0d want 15", n_exec); else pass++;
    total++; if (done_cyc !== 41 || n_done !== 1) $display("FAIL ign_done got cyc %0d n %0d want 41 1", done_cyc, n_done); else pass++;
    total++; if (busy !== 1'b0 || accum_limit !== 4'd15) $display("FAIL ign_end got busy %b alim %0d want 0 15", busy, accum_limit); else pass++;
  endtask

  task automatic test_reset_mid_load();
    int nd;
    nd = 0;
    k_len = 4'd4; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    reset = 0;
    #1;
    total++; if ({busy, done, err} !== 3'b000) $display("FAIL mid_rst_status got %b want 000", {busy, done, err}); else pass++;
    total++; if ({act_rd, wgt_rd, ofifo_wr} !== 3'b000 || inst_w !== 2'b00) $display("FAIL mid_rst_strobes got %b inst %b want 000 00", {act_rd, wgt_rd, ofifo_wr}, inst_w); else pass++;
    total++; if (accum_limit !== 4'd0 || ofifo_row !== '0 || ofifo_data !== exp_row(0)) $display("FAIL mid_rst_regs got alim %0d row %0d want 0 0", accum_limit, ofifo_row); else pass++;
    for (int i = 0; i < 3; i++) begin tick(); if (done) nd++; end
    reset = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (done) nd++; end
    total++; if (nd !== 0) $display("FAIL mid_rst_no_done got %0d want 0", nd); else pass++;
    run(4'd4, -1, -1, 0, 0, 0, -1);
    total++; if (clear_cyc !== 1 || n_exec !== 4) $display("FAIL mid_rst_rerun got clear %0d exec %0d want 1 4", clear_cyc, n_exec); else pass++;
    total++; if (done_cyc !== 30) $display("FAIL mid_rst_done got %0d want 30", done_cyc); else pass++;
  endtask

  initial begin
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) os_output[PB*(C*r + c) +: PB] = PB'(16'hA000 + 16*r + c);
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_late_ready();
    test_error_ignore();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
